// File: rtl/seg7_scan_decoder.sv
// Recovers the four displayed hex digits from a multiplexed, active-low 7-segment scan bus.
// Optional build macro SEG7DEC_TIMEOUT_EN adds the stale-frame timeout counter.
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  AN,
  input  logic [6:0]  a_to_g,
  input  logic        point,
  output logic [15:0] disp_value,
  output logic [3:0]  dp,
  output logic [3:0]  blank,
  output logic [3:0]  err,
  output logic        frame_valid,
  output logic        stale
);

  localparam logic [7:0] CAP_CNT = 8'(STABLE_CYCLES - 1);

  logic [11:0] sync1, sync2, prev;
  logic [7:0]  cnt, cnt_next;
  logic [3:0]  s_an;
  logic [6:0]  s_seg;
  logic        s_pt;
  logic [1:0]  idx;
  logic        one_low;
  logic        capture;
  logic        commit;
  logic [3:0]  dec_nib;
  logic        dec_blank, dec_err;
  logic [15:0] sh_val;
  logic [3:0]  sh_dp, sh_blank, sh_err;
  logic [3:0]  seen;

  assign {s_an, s_seg, s_pt} = sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
      cnt   <= '0;
    end else begin
      sync1 <= {AN, a_to_g, point};
      sync2 <= sync1;
      prev  <= sync2;
      cnt   <= cnt_next;
    end
  end

  // cnt_next equals (cycles the word has been present in sync2) - 1
  always_comb begin
    cnt_next = 8'd0;
    if (sync2 == prev)
      cnt_next = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  end

  always_comb begin
    idx     = 2'd0;
    one_low = 1'b0;
    case (s_an)
      4'b1110: begin idx = 2'd0; one_low = 1'b1; end
      4'b1101: begin idx = 2'd1; one_low = 1'b1; end
      4'b1011: begin idx = 2'd2; one_low = 1'b1; end
      4'b0111: begin idx = 2'd3; one_low = 1'b1; end
      default: begin idx = 2'd0; one_low = 1'b0; end
    endcase
  end

  assign capture = one_low && (cnt_next == CAP_CNT);
  assign commit  = (seen == 4'hF);

  always_comb begin
    dec_nib   = 4'h0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (s_seg)
      7'b0000001: dec_nib = 4'h0;
      7'b1001111: dec_nib = 4'h1;
      7'b0010010: dec_nib = 4'h2;
      7'b0000110: dec_nib = 4'h3;
      7'b1001100: dec_nib = 4'h4;
      7'b0100100: dec_nib = 4'h5;
      7'b0100000: dec_nib = 4'h6;
      7'b0001111: dec_nib = 4'h7;
      7'b0000000: dec_nib = 4'h8;
      7'b0000100: dec_nib = 4'h9;
      7'b0001000: dec_nib = 4'hA;
      7'b1100000: dec_nib = 4'hB;
      7'b0110001: dec_nib = 4'hC;
      7'b1000010: dec_nib = 4'hD;
      7'b0110000: dec_nib = 4'hE;
      7'b0111000: dec_nib = 4'hF;
      7'b1111111: dec_blank = 1'b1;
      default:    dec_err = 1'b1;
    endcase
  end

  // A capture coinciding with commit goes into the freshly cleared mask
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_val      <= '0;
      sh_dp       <= '0;
      sh_blank    <= '0;
      sh_err      <= '0;
      seen        <= '0;
      disp_value  <= '0;
      dp          <= '0;
      blank       <= '0;
      err         <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= commit;
      if (commit) begin
        disp_value <= sh_val;
        dp         <= sh_dp;
        blank      <= sh_blank;
        err        <= sh_err;
      end
      seen <= (commit ? 4'h0 : seen) | (capture ? (4'b0001 << idx) : 4'b0000);
      if (capture) begin
        sh_val[{idx, 2'b00} +: 4] <= dec_nib;
        sh_dp[idx]                <= ~s_pt;
        sh_blank[idx]             <= dec_blank;
        sh_err[idx]               <= dec_err;
      end
    end
  end

`ifdef SEG7DEC_TIMEOUT_EN
  localparam logic [23:0] TO_LIMIT = 24'(TIMEOUT_CYCLES);
  logic [23:0] to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      stale  <= 1'b0;
    end else begin
      if (frame_valid)
        to_cnt <= '0;
      else if (to_cnt != 24'hFFFFFF)
        to_cnt <= to_cnt + 24'd1;
      if (frame_valid)
        stale <= 1'b0;
      else if (to_cnt >= TO_LIMIT)
        stale <= 1'b1;
    end
  end
`else
  assign stale = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: scans digits onto the bus and checks committed frames.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  AN = 4'b1111;
  logic [6:0]  a_to_g = 7'b1111111;
  logic        point = 1'b1;
  logic [15:0] disp_value;
  logic [3:0]  dp, blank, err;
  logic        frame_valid, stale;

  int passes = 0;
  int fails  = 0;
  int total  = 0;
  int fv_count = 0;
  int fv_base  = 0;

  localparam logic [6:0] G1 = 7'b1001111, G2 = 7'b0010010, G3 = 7'b0000110, G4 = 7'b1001100;
  localparam logic [6:0] G5 = 7'b0100100, G6 = 7'b0100000, G7 = 7'b0001111, G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0000100, GA = 7'b0001000, GB = 7'b1100000, GC = 7'b0110001;
  localparam logic [6:0] GD = 7'b1000010, GE = 7'b0110000, GF = 7'b0111000;

  seg7_scan_decoder #(.STABLE_CYCLES(16), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .AN(AN), .a_to_g(a_to_g), .point(point),
    .disp_value(disp_value), .dp(dp), .blank(blank), .err(err),
    .frame_valid(frame_valid), .stale(stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_valid === 1'b1) fv_count++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input logic pt, input int n);
    AN = an;
    a_to_g = seg;
    point = pt;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(4'b1111, 7'b1111111, 1'b1, n);
  endtask

  task automatic scan4(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3);
    drive(4'b1110, s0, 1'b1, 20);
    drive(4'b1101, s1, 1'b1, 20);
    drive(4'b1011, s2, 1'b1, 20);
    drive(4'b0111, s3, 1'b1, 20);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_disp", disp_value, 16'h0);
    check("rst_dp", 16'(dp), 16'h0);
    check("rst_blank", 16'(blank), 16'h0);
    check("rst_err", 16'(err), 16'h0);
    check("rst_fv", 16'(frame_valid), 16'h0);
    check("rst_stale", 16'(stale), 16'h0);
    rst = 1'b0;
    idle(5);

    // basic scan 1,2,3,4
    fv_base = fv_count;
    drive(4'b1110, G1, 1'b1, 20);
    drive(4'b1101, G2, 1'b1, 20);
    drive(4'b1011, G3, 1'b1, 20);
    check("partial_fv", 16'(fv_count - fv_base), 16'd0);
    check("partial_disp", disp_value, 16'h0);
    drive(4'b0111, G4, 1'b1, 20);
    idle(10);
    check("scan_fv", 16'(fv_count - fv_base), 16'd1);
    check("scan_disp", disp_value, 16'h4321);
    check("scan_dp", 16'(dp), 16'h0);
    check("scan_blank", 16'(blank), 16'h0);
    check("scan_err", 16'(err), 16'h0);

    // short glitch on digit 0 must not be captured
    fv_base = fv_count;
    drive(4'b1110, G5, 1'b1, 20);
    drive(4'b1110, G8, 1'b1, 10);
    drive(4'b1101, G6, 1'b1, 20);
    drive(4'b1011, G7, 1'b1, 20);
    drive(4'b0111, G9, 1'b1, 20);
    idle(10);
    check("glitch_fv", 16'(fv_count - fv_base), 16'd1);
    check("glitch_disp", disp_value, 16'h9765);

    // multi-low and all-high words are ignored mid-frame
    fv_base = fv_count;
    drive(4'b1110, GA, 1'b1, 20);
    drive(4'b1101, GB, 1'b1, 20);
    drive(4'b1011, GC, 1'b1, 20);
    drive(4'b1100, G8, 1'b0, 50);
    idle(50);
    check("ignore_fv", 16'(fv_count - fv_base), 16'd0);
    drive(4'b0111, GD, 1'b1, 20);
    idle(10);
    check("ignore_fv_after", 16'(fv_count - fv_base), 16'd1);
    check("ignore_disp", disp_value, 16'hDCBA);

    // error, blank and decimal point flags
    fv_base = fv_count;
    drive(4'b1110, GE, 1'b1, 20);
    drive(4'b1101, 7'b1111111, 1'b1, 20);
    drive(4'b1011, 7'b1111110, 1'b0, 20);
    drive(4'b0111, GF, 1'b1, 20);
    idle(10);
    check("flags_fv", 16'(fv_count - fv_base), 16'd1);
    check("flags_disp", disp_value, 16'hF00E);
    check("flags_err", 16'(err), 16'h4);
    check("flags_blank", 16'(blank), 16'h2);
    check("flags_dp", 16'(dp), 16'h4);

    // reset mid-frame discards captured digits
    drive(4'b1110, G1, 1'b1, 20);
    drive(4'b1101, G2, 1'b1, 20);
    drive(4'b1011, G3, 1'b1, 20);
    AN = 4'b1111; a_to_g = 7'b1111111; point = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_disp", disp_value, 16'h0);
    check("mid_rst_dp", 16'(dp), 16'h0);
    check("mid_rst_blank", 16'(blank), 16'h0);
    check("mid_rst_err", 16'(err), 16'h0);
    rst = 1'b0;
    idle(5);
    fv_base = fv_count;
    drive(4'b0111, G4, 1'b1, 20);
    idle(5);
    check("post_rst_fv", 16'(fv_count - fv_base), 16'd0);
    check("post_rst_disp", disp_value, 16'h0);
    scan4(G1, G2, G3, G4);
    idle(10);
    check("post_rst_scan_fv", 16'(fv_count - fv_base), 16'd1);
    check("post_rst_scan_disp", disp_value, 16'h4321);

    // timeout behaviour
    idle(130);
`ifdef SEG7DEC_TIMEOUT_EN
    check("stale_set", 16'(stale), 16'h1);
    scan4(G5, G6, G7, G8);
    idle(5);
    check("stale_clear", 16'(stale), 16'h0);
`else
    check("stale_tied", 16'(stale), 16'h0);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
